// File: rtl/matrix_operand_loader.sv
// Collects eight signed elements (A row-major, then B row-major) and hands them to the 2x2 multiplier.
// Latency: last element accepted at edge N -> start high during cycle N+1; operands stay frozen until mul_done.
// Backpressure: in_ready is low in FIRE/WAIT and during reset. Optional WAIT timeout under MATLOAD_TIMEOUT_EN.
module matrix_operand_loader #(
    parameter int ELEM_W      = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic        [ELEM_W-1:0] in_data,
    output logic                     in_ready,
    input  logic                     abort,
    output logic                     start,
    output logic signed [ELEM_W-1:0] a0,
    output logic signed [ELEM_W-1:0] a1,
    output logic signed [ELEM_W-1:0] a2,
    output logic signed [ELEM_W-1:0] a3,
    output logic signed [ELEM_W-1:0] b0,
    output logic signed [ELEM_W-1:0] b1,
    output logic signed [ELEM_W-1:0] b2,
    output logic signed [ELEM_W-1:0] b3,
    input  logic                     mul_done,
    output logic                     busy,
    output logic        [CNT_W-1:0]  frames,
    output logic                     timeout_err
);

    typedef enum logic [1:0] {LOAD, FIRE, WAIT} state_t;

    state_t            state, state_nxt;
    logic [2:0]        idx;
    logic [ELEM_W-1:0] ops [8];
    logic              xfer;
    logic              timeout_hit;

    // abort beats a simultaneous handshake: the element is dropped
    assign in_ready = (state == LOAD) && !rst;
    assign xfer     = in_valid && in_ready && !abort;
    assign busy     = (state != LOAD);

    assign a0 = ops[0];
    assign a1 = ops[1];
    assign a2 = ops[2];
    assign a3 = ops[3];
    assign b0 = ops[4];
    assign b1 = ops[5];
    assign b2 = ops[6];
    assign b3 = ops[7];

`ifdef MATLOAD_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TCW-1:0] TLAST = TCW'(TIMEOUT_CYC - 1);

    logic [TCW-1:0] wait_cnt;

    // wait_cnt holds the number of completed WAIT cycles; the edge closing cycle TIMEOUT_CYC times out
    assign timeout_hit = (state == WAIT) && !mul_done && (wait_cnt == TLAST);

    // WAIT cycle counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != WAIT) wait_cnt <= '0;
            else               wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: if (xfer && idx == 3'd7) state_nxt = FIRE;
            FIRE: state_nxt = WAIT;
            WAIT: if (mul_done || timeout_hit) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // state, element index, operand store, start pulse and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LOAD;
            idx    <= 3'd0;
            start  <= 1'b0;
            frames <= '0;
            for (int i = 0; i < 8; i++) ops[i] <= '0;
        end else begin
            state <= state_nxt;
            // start is high exactly while the FSM sits in FIRE
            start <= (state_nxt == FIRE);
            if (state == LOAD) begin
                if (abort) begin
                    idx <= 3'd0;
                end else if (xfer) begin
                    ops[idx] <= in_data;
                    idx      <= idx + 3'd1;  // 7 wraps to 0 for the next frame
                end
            end
            if (state == WAIT && mul_done) frames <= frames + 1'b1;
        end
    end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: loading, gaps, abort, WAIT behaviour, async reset, optional timeout.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// mul_done is modelled by the bench a fixed number of cycles after start.
module tb_matrix_operand_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        in_ready;
    logic        abort;
    logic        start;
    logic [3:0]  a0, a1, a2, a3, b0, b1, b2, b3;
    logic        mul_done;
    logic        busy;
    logic [15:0] frames;
    logic        timeout_err;

    int n_assert = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int start_base;
    int exp_frames = 0;

    matrix_operand_loader #(.ELEM_W(4), .CNT_W(16), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .abort(abort), .start(start),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .mul_done(mul_done), .busy(busy), .frames(frames),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (start) start_cnt++;

    function automatic logic [31:0] ops();
        return {a0, a1, a2, a3, b0, b1, b2, b3};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // send one element per cycle, msb nibble first
    task automatic load8(input logic [31:0] v);
        for (int i = 7; i >= 0; i--) begin
            in_valid = 1'b1;
            in_data  = v[i*4 +: 4];
            step();
        end
        in_valid = 1'b0;
    endtask

    // assert mul_done after n cycles of WAIT
    task automatic finish_frame(input int n);
        for (int i = 0; i < n; i++) step();
        mul_done = 1'b1;
        step();
        mul_done = 1'b0;
        exp_frames++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; abort = 1'b0; mul_done = 1'b0;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_ops", ops(), 32'h0);
        chk("rst_frames", 32'(frames), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        #9 rst = 1'b0;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // 1: back-to-back load 1..8
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i);
            step();
            if (i == 7) chk("t1_no_early_start", 32'(start), 32'd0);
        end
        in_valid = 1'b0;
        chk("t1_start", 32'(start), 32'd1);
        chk("t1_ops", ops(), 32'h12345678);
        chk("t1_ready_fire", 32'(in_ready), 32'd0);
        step();
        chk("t1_start_one_cycle", 32'(start), 32'd0);
        chk("t1_busy_wait", 32'(busy), 32'd1);
        chk("t1_ready_wait", 32'(in_ready), 32'd0);
        finish_frame(4);
        chk("t1_frames", 32'(frames), 32'(exp_frames));
        chk("t1_ready_after_done", 32'(in_ready), 32'd1);

        // mul_done in LOAD is ignored
        mul_done = 1'b1; step(); mul_done = 1'b0;
        chk("load_done_ignored", 32'(frames), 32'(exp_frames));

        // 2: extreme values with a gap before each element
        begin
            logic [31:0] v;
            v = 32'h87F08877;
            for (int i = 7; i >= 0; i--) begin
                in_valid = 1'b0; in_data = 4'h5;
                step();
                in_valid = 1'b1; in_data = v[i*4 +: 4];
                step();
                if (i == 1) chk("t2_gap_no_start", 32'(busy), 32'd0);
            end
            in_valid = 1'b0;
            chk("t2_start", 32'(start), 32'd1);
            chk("t2_ops", ops(), v);
        end
        finish_frame(5);
        chk("t2_frames", 32'(frames), 32'(exp_frames));

        // 3: abort with a simultaneous valid, then a fresh frame
        start_base = start_cnt;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 4'h9; step();
        end
        in_valid = 1'b1; in_data = 4'hC; abort = 1'b1; step();
        abort = 1'b0; in_valid = 1'b0;
        chk("t3_abort_drop", ops(), 32'h99908877);
        load8(32'h20021111);
        chk("t3_ops", ops(), 32'h20021111);
        chk("t3_start", 32'(start), 32'd1);
        step();
        chk("t3_one_start", 32'(start_cnt - start_base), 32'd1);
        finish_frame(5);

        // 4: in WAIT, valid data and abort are ignored; three more frames
        for (int f = 0; f < 3; f++) begin
            load8(32'h12345678);
            step();
            in_valid = 1'b1; in_data = 4'h5; abort = 1'b1;
            step();
            chk("t4_ready_wait", 32'(in_ready), 32'd0);
            abort = 1'b0;
            step();
            in_valid = 1'b0;
            chk("t4_ops_frozen", ops(), 32'h12345678);
            chk("t4_busy", 32'(busy), 32'd1);
            finish_frame(3);
            chk("t4_ready_next", 32'(in_ready), 32'd1);
        end
        chk("t4_frames", 32'(frames), 32'(exp_frames));

        // default build: WAIT never times out
`ifndef MATLOAD_TIMEOUT_EN
        load8(32'h11111111);
        for (int i = 0; i < 20; i++) step();
        chk("wait_forever_busy", 32'(busy), 32'd1);
        chk("no_timeout_err", 32'(timeout_err), 32'd0);
        finish_frame(0);
        chk("late_done_frames", 32'(frames), 32'(exp_frames));
`endif

        // 5a: async reset mid-cycle in WAIT
        load8(32'hABCDEF01);
        step();
        #2 rst = 1'b1;
        #1;
        chk("t5_wait_ops", ops(), 32'h0);
        chk("t5_wait_busy", 32'(busy), 32'd0);
        chk("t5_wait_frames", 32'(frames), 32'd0);
        chk("t5_wait_ready", 32'(in_ready), 32'd0);
        #3 rst = 1'b0;
        exp_frames = 0;
        step();

        // 5b: async reset in LOAD at idx 5
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 4'h3; step();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_load_ops", ops(), 32'h0);
        #3 rst = 1'b0;
        step();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 4'h6; step();
        end
        chk("t5_needs_eight", 32'(busy), 32'd0);
        in_data = 4'h7; step();
        in_valid = 1'b0;
        chk("t5_start_after_eight", 32'(start), 32'd1);
        chk("t5_ops", ops(), 32'h66666667);
        step();
        finish_frame(5);
        chk("t5_frames", 32'(frames), 32'(exp_frames));

`ifdef MATLOAD_TIMEOUT_EN
        // 6: timeout after 16 WAIT cycles, then a normal frame
        load8(32'h12345678);
        for (int i = 0; i < 16; i++) step();
        chk("t6_still_wait", 32'(busy), 32'd1);
        chk("t6_no_err_yet", 32'(timeout_err), 32'd0);
        step();
        chk("t6_timeout_err", 32'(timeout_err), 32'd1);
        chk("t6_back_to_load", 32'(in_ready), 32'd1);
        chk("t6_frames_unchanged", 32'(frames), 32'(exp_frames));
        load8(32'h11112222);
        step();
        finish_frame(5);
        chk("t6_frames_next", 32'(frames), 32'(exp_frames));
        chk("t6_err_sticky", 32'(timeout_err), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
